inst_mem_loader: RTL

- Write-side counterpart of the instruction fetch path: loads a program into the byte-addressed instruction memory before execution.
- Accepts 32-bit instruction words over a valid/ready stream and writes each word as 4 bytes, little-endian (byte 0 = word[7:0] at the lowest address).
- Bytes go to consecutive addresses starting at the text-segment base, in the same layout the fetch unit reads.
- Sits between the testbench/host program source and the instruction memory's byte write port.

---
 rtl/inst_mem_loader_if.sv | 29 ++
 rtl/inst_mem_loader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/inst_mem_loader_if.sv
// Word stream in, byte write port out, for the instruction memory loader.
// Combinational bundle only; no latency of its own.
// Backpressure: word_ready from the loader throttles the word source.
//
// Signals:
//   word_valid / word_data / word_last : word source -> loader
//   word_ready                         : loader -> word source
//   mem_we / mem_addr / mem_wdata      : loader -> instruction memory byte port
interface inst_mem_loader_if;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    // Host side: drives words, observes the memory write port.
    modport master (
        output word_valid, word_data, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  word_valid, word_data, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Loads 32-bit instruction words into byte-addressed memory, little-endian, from BASE_ADDR.
// First byte write 1 cycle after handshake; 4 byte writes per word, at most one word per 5 cycles.
// Backpressure: word_ready only in ACCEPT; a held word_valid is not consumed until then.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : begin a load session (sampled in IDLE/DONE only)
//   bus (slave)    : word stream in, memory byte write port out
//   busy / done    : session in progress / session finished
//   error          : MAX_WORDS reached without word_last
//   word_count     : words fully written this (or the last) session, saturating
module inst_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h00400000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    inst_mem_loader_if.slave    bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         word_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] ptr;        // byte address of byte 0 of the current word
    logic [31:0] word_q;
    logic        last_q;
    logic [1:0]  byte_idx;   // byte currently presented on the write port

    logic [15:0] count_inc;
    logic [1:0]  byte_nxt;
    logic [31:0] word_shift;
    logic [7:0]  next_byte;

    assign count_inc  = (word_count == 16'hFFFF) ? word_count : word_count + 16'd1;
    assign byte_nxt   = byte_idx + 2'd1;
    assign word_shift = word_q >> {byte_nxt, 3'b000};
    assign next_byte  = word_shift[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= BASE_ADDR;
            word_q         <= 32'd0;
            last_q         <= 1'b0;
            byte_idx       <= 2'd0;
            bus.word_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= 32'd0;
            bus.mem_wdata  <= 8'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            word_count     <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= ACCEPT;
                        ptr            <= BASE_ADDR;
                        word_count     <= 16'd0;
                        done           <= 1'b0;
                        error          <= 1'b0;
                        busy           <= 1'b1;
                        bus.word_ready <= 1'b1;
                    end
                end

                ACCEPT: begin
                    if (bus.word_valid && bus.word_ready) begin
                        // Byte 0 is presented straight from the input word so the
                        // first write lands the cycle after the handshake.
                        word_q         <= bus.word_data;
                        last_q         <= bus.word_last;
                        byte_idx       <= 2'd0;
                        bus.word_ready <= 1'b0;
                        bus.mem_we     <= 1'b1;
                        bus.mem_addr   <= ptr;
                        bus.mem_wdata  <= bus.word_data[7:0];
                        state          <= WRITE;
                    end
                end

                WRITE: begin
                    if (byte_idx == 2'd3) begin
                        bus.mem_we <= 1'b0;
                        ptr        <= ptr + 32'd4;
                        word_count <= count_inc;
                        if (last_q) begin
                            // word_last wins even if this word also hits MAX_WORDS.
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if ({16'd0, count_inc} == MAX_WORDS) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state          <= ACCEPT;
                            bus.word_ready <= 1'b1;
                        end
                    end else begin
                        byte_idx      <= byte_nxt;
                        bus.mem_addr  <= ptr + {30'd0, byte_nxt};
                        bus.mem_wdata <= next_byte;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
